// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-client ALU arbiter: function codes and FSM states.
package alu_arbiter_pkg;

  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_SUB = 3'b110;
  localparam logic [2:0] FN_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by both clients; unknown function codes yield zero.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FW    = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [FW-1:0]    f,
  output logic [WIDTH-1:0] s
);

  always_comb begin
    s = '0;
    if (f == FW'(FN_AND))      s = a & b;
    else if (f == FW'(FN_OR))  s = a | b;
    else if (f == FW'(FN_ADD)) s = a + b;
    else if (f == FW'(FN_SUB)) s = a - b;
    else if (f == FW'(FN_SLT)) s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting one of two clients a single shared ALU; result is
// held in RESP until the owning client acknowledges it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [FW-1:0]    f0,
  input  logic [FW-1:0]    f1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             rzero,
  input  logic             rack0,
  input  logic             rack1
);

  state_t           state_q;
  logic             owner_q;
  logic             last_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [FW-1:0]    f_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rzero_q;
  logic             rvalid0_q;
  logic             rvalid1_q;

  logic             win1;
  logic             owner_rack;
  logic [WIDTH-1:0] alu_s;

  // On contention the client not served last wins; last_q holds the last owner.
  assign win1       = req1 && (!req0 || !last_q);
  assign owner_rack = owner_q ? rack1 : rack0;

  // Grants are combinational but must vanish the instant reset is applied.
  assign gnt0 = !rst && (state_q == ST_IDLE) && req0 && !win1;
  assign gnt1 = !rst && (state_q == ST_IDLE) && win1;

  alu #(
    .WIDTH(WIDTH),
    .FW   (FW)
  ) u_alu (
    .a(a_q),
    .b(b_q),
    .f(f_q),
    .s(alu_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      f_q       <= '0;
      rdata_q   <= '0;
      rzero_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            a_q     <= win1 ? a1 : a0;
            b_q     <= win1 ? b1 : b0;
            f_q     <= win1 ? f1 : f0;
            owner_q <= win1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rdata_q   <= alu_s;
          rzero_q   <= (alu_s == '0);
          rvalid0_q <= !owner_q;
          rvalid1_q <= owner_q;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_rack) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            last_q    <= owner_q;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;
  assign rzero   = rzero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, arbitration and reset
// sequences, and randomized traffic against a behavioural model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, rack0, rack1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   f0, f1;
  logic         gnt0, gnt1, rvalid0, rvalid1, rzero;
  logic [W-1:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int last_served;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .FW(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .f0(f0), .f1(f1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rzero(rzero),
    .rack0(rack0), .rack1(rack1)
  );

  typedef struct {
    int         client;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0] f;
    logic [W-1:0] exp;
    int         hold;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU written from the function-code table with plain arithmetic.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] f);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return W'((longint'(a) + longint'(b)) % (64'd1 << W));
      3'b110:  return W'((longint'(a) - longint'(b) + (64'd1 << W)) % (64'd1 << W));
      3'b111:  return (sa < sb) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects inputs already driven; checks grant, latency, result, hold and completion.
  task automatic run_op(input int exp_c, input bit keep_req, input int hold,
                        input logic [W-1:0] ea, input string tag);
    int waited;
    waited = 0;
    #1;
    while (!(gnt0 || gnt1) && waited < 8) begin
      tick();
      @(negedge clk);
      waited++;
    end
    chk({tag, " gnt0"}, gnt0, W'(exp_c == 0));
    chk({tag, " gnt1"}, gnt1, W'(exp_c == 1));
    tick();
    if (exp_c == 0) begin
      if (!keep_req) req0 = 1'b0;
      a0 = $urandom; b0 = $urandom; f0 = 3'($urandom);
    end else begin
      if (!keep_req) req1 = 1'b0;
      a1 = $urandom; b1 = $urandom; f1 = 3'($urandom);
    end
    @(negedge clk);
    chk({tag, " exec no gnt"}, W'(gnt0 | gnt1), '0);
    chk({tag, " exec no rvalid"}, W'(rvalid0 | rvalid1), '0);
    tick();
    @(negedge clk);
    chk({tag, " rvalid0"}, rvalid0, W'(exp_c == 0));
    chk({tag, " rvalid1"}, rvalid1, W'(exp_c == 1));
    chk({tag, " rdata"}, rdata, ea);
    chk({tag, " rzero"}, rzero, W'(ea == '0));
    for (int i = 0; i < hold; i++) begin
      if (exp_c == 0) rack1 = 1'b1; else rack0 = 1'b1;
      tick();
      rack0 = 1'b0; rack1 = 1'b0;
      @(negedge clk);
      chk({tag, " hold rvalid"}, W'(exp_c == 0 ? rvalid0 : rvalid1), W'(1));
      chk({tag, " hold rdata"}, rdata, ea);
      chk({tag, " hold no gnt"}, W'(gnt0 | gnt1), '0);
    end
    if (exp_c == 0) rack0 = 1'b1; else rack1 = 1'b1;
    tick();
    rack0 = 1'b0; rack1 = 1'b0;
    @(negedge clk);
    chk({tag, " done rvalid"}, W'(rvalid0 | rvalid1), '0);
    last_served = exp_c;
    $display("op %s: client %0d rdata %0h", tag, exp_c, ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [1:0] r;
    logic [W-1:0] ea;

    vecs[0]  = '{0, 32'd5, 32'd7, 3'b010, 32'd12, 0};
    vecs[1]  = '{1, 32'd3, 32'd5, 3'b110, 32'hFFFF_FFFE, 0};
    vecs[2]  = '{0, 32'd9, 32'd9, 3'b011, 32'd0, 0};
    vecs[3]  = '{1, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 0};
    vecs[4]  = '{0, 32'hF0F0_00FF, 32'h0FF0_F00F, 3'b000, 32'h00F0_000F, 4};
    vecs[5]  = '{1, 32'hF0F0_00FF, 32'h0FF0_F00F, 3'b001, 32'hFFF0_F0FF, 1};
    vecs[6]  = '{0, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 0};
    vecs[7]  = '{1, 32'd1, 32'hFFFF_FFFF, 3'b111, 32'd0, 0};
    vecs[8]  = '{0, 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF, 0};
    vecs[9]  = '{1, 32'd7, 32'd7, 3'b100, 32'd0, 0};
    vecs[10] = '{0, 32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'd0, 0};
    vecs[11] = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'd1, 0};

    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; rack0 = 1'b0; rack1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; f0 = '0; f1 = '0;
    last_served = 1;
    #12;
    chk("reset gnt0", gnt0, '0);
    chk("reset gnt1", gnt1, '0);
    chk("reset rvalid", W'(rvalid0 | rvalid1), '0);
    chk("reset rdata", rdata, '0);
    chk("reset rzero", rzero, '0);
    req0 = 1'b0; req1 = 1'b0;
    #10 rst = 1'b0;

    // A stray acknowledge while idle must not disturb anything.
    tick();
    rack0 = 1'b1; rack1 = 1'b1;
    tick();
    rack0 = 1'b0; rack1 = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].client == 0) begin
        a0 = vecs[i].a; b0 = vecs[i].b; f0 = vecs[i].f; req0 = 1'b1;
      end else begin
        a1 = vecs[i].a; b1 = vecs[i].b; f1 = vecs[i].f; req1 = 1'b1;
      end
      run_op(vecs[i].client, 1'b0, vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));
      tick();
    end

    // Both clients hold requests continuously: grants must alternate.
    a0 = 32'd10; b0 = 32'd20; f0 = 3'b010;
    a1 = 32'd50; b1 = 32'd8;  f1 = 3'b110;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 1 - last_served;
      ea = (w == 0) ? ref_alu(a0, b0, f0) : ref_alu(a1, b1, f1);
      run_op(w, 1'b1, (k == 1) ? 2 : 0, ea, $sformatf("rr%0d", k));
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    for (int k = 0; k < 40; k++) begin
      r = 2'($urandom_range(1, 3));
      a0 = $urandom; b0 = $urandom; f0 = 3'($urandom);
      a1 = $urandom; b1 = $urandom; f1 = 3'($urandom);
      if (k % 5 == 0) begin b0 = a0; b1 = a1; end
      req0 = r[0]; req1 = r[1];
      w = (r == 2'b11) ? 1 - last_served : (r[1] ? 1 : 0);
      ea = (w == 0) ? ref_alu(a0, b0, f0) : ref_alu(a1, b1, f1);
      run_op(w, 1'b0, $urandom_range(0, 2), ea, $sformatf("rnd%0d", k));
      req0 = 1'b0; req1 = 1'b0;
      tick();
    end

    // Serve client 0 so the pointer would favour client 1 absent a reset.
    a0 = 32'd1; b0 = 32'd2; f0 = 3'b001; req0 = 1'b1;
    run_op(0, 1'b0, 0, 32'd3, "pre_rst");
    tick();
    a1 = 32'd3; b1 = 32'd5; f1 = 3'b010; req1 = 1'b1;
    #1;
    chk("mid gnt1", gnt1, W'(1));
    tick();
    req1 = 1'b0;
    tick();
    #2;
    chk("mid resp rvalid1", rvalid1, W'(1));
    rst = 1'b1;
    #1;
    chk("async rst rvalid", W'(rvalid0 | rvalid1), '0);
    chk("async rst rdata", rdata, '0);
    chk("async rst rzero", rzero, '0);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("async rst gnt", W'(gnt0 | gnt1), '0);
    #2 rst = 1'b0;
    last_served = 1;
    chk("post rst rvalid", W'(rvalid0 | rvalid1), '0);
    a0 = 32'd4; b0 = 32'd4; f0 = 3'b110;
    run_op(0, 1'b0, 0, 32'd0, "post_rst");
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter FW, default 3, meaning ALU function-code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  client operation request, level, held until granted.
REQ-006 a0, b0, a1, b1  input  WIDTH each  client operands.
REQ-007 f0, f1  input  FW each  client function code.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: operands captured this edge.
REQ-009 rvalid0, rvalid1  output  1 each  result available to that client.
REQ-010 rdata  output  WIDTH  registered result, shared by both clients.
REQ-011 rzero  output  1  registered flag, high when rdata == 0.
REQ-012 rack0, rack1  input  1 each  client accepts result.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 IDLE: no req -> stay; any req -> select winner, latch its a/b/f and owner id, assert that client's gnt combinationally this cycle, go EXEC.
REQ-015 Arbitration: single req wins outright; simultaneous req0 and req1 -> winner is client not served last.
REQ-016 Priority pointer SHALL update only on completion (rack edge in RESP), to point away from the client just served.
REQ-017 EXEC: one cycle; ALU evaluates latched operands; at edge rdata/rzero register, go RESP.
REQ-018 RESP: rvalid of owner only high; rdata/rzero stable; stays until owner's rack high; at that edge rvalid drops, go IDLE.
REQ-019 Non-owner rack, or rack outside RESP, SHALL be ignored.
REQ-020 Minimum latency: gnt cycle to rvalid = 2 cycles; minimum 3 cycles per operation; no new grant while in EXEC or RESP.
REQ-021 gnt SHALL never be high outside IDLE; at most one gnt, at most one rvalid high per cycle.
REQ-022 Function codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed, result 1 or 0); all other codes -> result 0.
REQ-023 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow signalling.
REQ-024 Request deasserted before grant SHALL leave no trace; req held after grant is treated as a new request at next IDLE.

Reset
REQ-025 rst high SHALL force IDLE, gnt0/1 = 0, rvalid0/1 = 0, rdata = 0, rzero = 0, pointer favouring client 0, immediately and regardless of clock.
REQ-026 Reset during EXEC or RESP SHALL discard the in-flight operation; no rvalid after release until a new grant.
REQ-027 First edge after rst release SHALL be able to grant.

Structure
REQ-028 Shared package SHALL hold function-code constants (AND/OR/ADD/SUB/SLT) and FSM state encoding.
REQ-029 Combinational ALU SHALL be the single sub-module, named alu (ports a, b, f, s), instantiated once; arbiter owns all registers.

Verification
REQ-030 req0 alone, a0=5, b0=7, f0=010 -> gnt0 pulse, rvalid0 two cycles later, rdata=12, rzero=0.
REQ-031 req1 alone, a1=3, b1=5, f1=110 -> rdata=0xFFFFFFFE; then f1=111 a1=0xFFFFFFFF b1=1 -> rdata=1.
REQ-032 req0 and req1 both held from reset -> order 0,1,0,1 grants; each gnt only after previous rack.
REQ-033 Result with rack0 held low 4 cycles -> rvalid0 and rdata stable 4+ cycles; rack1 pulses ignored; no gnt during wait.
REQ-034 rst asserted mid-RESP (async, between edges) -> rvalid/gnt/rdata 0 immediately; state IDLE; next grant to client 0 on simultaneous req.
REQ-035 f0=011, a0=b0=9 -> rdata=0, rzero=1.
